// File: rtl/pid_pkg.sv
// Shared constants for the PID sequencer: FSM state codes, config addresses
// and reset values of the gains and setpoint.
package pid_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ERR  = 3'd1;
    localparam state_t ST_MUL0 = 3'd2;
    localparam state_t ST_MUL1 = 3'd3;
    localparam state_t ST_MUL2 = 3'd4;
    localparam state_t ST_UPD  = 3'd5;

    localparam logic [1:0] CFG_K1 = 2'd0;
    localparam logic [1:0] CFG_K2 = 2'd1;
    localparam logic [1:0] CFG_K3 = 2'd2;
    localparam logic [1:0] CFG_SP = 2'd3;

    localparam logic [15:0] K1_DEFAULT = 16'sd2;
    localparam logic [15:0] K2_DEFAULT = -16'sd2;
    localparam logic [15:0] K3_DEFAULT = 16'sd1;
    localparam logic [15:0] SP_DEFAULT = 16'd165;

endpackage

// File: rtl/pid_mac.sv
// Combinational multiply-accumulate: y = c + low W bits of signed a*b.
module pid_mac #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    logic signed [2*W-1:0] prod;

    assign prod = $signed(a) * $signed(b);
    assign y    = c + prod[W-1:0];

endmodule

// File: rtl/pid_sequencer.sv
// Incremental PID controller sharing one MAC across the three gain terms.
// Handshake: a sample transfers on a clock edge where in_valid && in_ready.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int          W      = 16,
    parameter logic [W-1:0] K1_DEF = K1_DEFAULT,
    parameter logic [W-1:0] K2_DEF = K2_DEFAULT,
    parameter logic [W-1:0] K3_DEF = K3_DEFAULT,
    parameter logic [W-1:0] SP_DEF = SP_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         clear,
    input  logic         cfg_we,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_data
);

    state_t       state;
    logic [W-1:0] y_reg;
    logic [W-1:0] k1_stg, k2_stg, k3_stg, sp_stg;
    logic [W-1:0] k1_act, k2_act, k3_act, sp_act;
    logic [W-1:0] e0, e1, e2;
    logic [W-1:0] acc, u_prev;
    logic [W-1:0] mac_a, mac_b, mac_c, mac_y;
    logic [W-1:0] u_next;

    assign in_ready = (state == ST_IDLE);
    assign u_next   = u_prev + acc;

    // MUL0 starts a fresh sum; MUL1/MUL2 add onto the running accumulator.
    always_comb begin
        mac_a = k1_act;
        mac_b = e0;
        mac_c = '0;
        case (state)
            ST_MUL1: begin
                mac_a = k2_act;
                mac_b = e1;
                mac_c = acc;
            end
            ST_MUL2: begin
                mac_a = k3_act;
                mac_b = e2;
                mac_c = acc;
            end
            default: ;
        endcase
    end

    pid_mac #(.W(W)) u_mac (
        .a (mac_a),
        .b (mac_b),
        .c (mac_c),
        .y (mac_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            y_reg     <= '0;
            k1_stg    <= K1_DEF;
            k2_stg    <= K2_DEF;
            k3_stg    <= K3_DEF;
            sp_stg    <= SP_DEF;
            k1_act    <= K1_DEF;
            k2_act    <= K2_DEF;
            k3_act    <= K3_DEF;
            sp_act    <= SP_DEF;
            e0        <= '0;
            e1        <= '0;
            e2        <= '0;
            acc       <= '0;
            u_prev    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            // Staging writes land in any state; the active copy below reads
            // the pre-write value, so a same-edge write waits for the next sample.
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_K1:  k1_stg <= cfg_data;
                    CFG_K2:  k2_stg <= cfg_data;
                    CFG_K3:  k3_stg <= cfg_data;
                    default: sp_stg <= cfg_data;
                endcase
            end

            if (clear) begin
                state  <= ST_IDLE;
                e1     <= '0;
                e2     <= '0;
                acc    <= '0;
                u_prev <= '0;
                out    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            y_reg  <= in;
                            k1_act <= k1_stg;
                            k2_act <= k2_stg;
                            k3_act <= k3_stg;
                            sp_act <= sp_stg;
                            state  <= ST_ERR;
                        end
                    end
                    ST_ERR: begin
                        e0    <= sp_act + ~y_reg + 1'b1;
                        state <= ST_MUL0;
                    end
                    ST_MUL0: begin
                        acc   <= mac_y;
                        state <= ST_MUL1;
                    end
                    ST_MUL1: begin
                        acc   <= mac_y;
                        state <= ST_MUL2;
                    end
                    ST_MUL2: begin
                        acc   <= mac_y;
                        state <= ST_UPD;
                    end
                    ST_UPD: begin
                        out       <= u_next;
                        u_prev    <= u_next;
                        e2        <= e1;
                        e1        <= e0;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// Bench for pid_sequencer: directed scenarios plus random samples, config
// writes and clears, scored against an arithmetic model of the PID law.
module tb_pid_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_v;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_v;
    logic         out_valid;
    logic         clear;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [W-1:0] cfg_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // model state: staging/active gains {K1,K2,K3,SP}, error history, last output
    logic [W-1:0] m_stg[4];
    logic [W-1:0] m_act[4];
    logic [W-1:0] m_e1, m_e2, m_u;

    always #5 clk = ~clk;

    pid_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_v),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_v),
        .out_valid (out_valid),
        .clear     (clear),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_stg[0] = 16'd2;
        m_stg[1] = 16'hFFFE;
        m_stg[2] = 16'd1;
        m_stg[3] = 16'd165;
        for (int i = 0; i < 4; i++) m_act[i] = m_stg[i];
        m_e1 = '0;
        m_e2 = '0;
        m_u  = '0;
    endfunction

    function automatic void model_accept(input logic [W-1:0] y, output logic [W-1:0] u,
                                         output logic [W-1:0] e0);
        logic [W-1:0] sum;
        for (int i = 0; i < 4; i++) m_act[i] = m_stg[i];
        e0  = m_act[3] - y;
        sum = m_act[0] * e0 + m_act[1] * m_e1 + m_act[2] * m_e2;
        u   = m_u + sum;
    endfunction

    function automatic void model_commit(input logic [W-1:0] u, input logic [W-1:0] e0);
        m_e2 = m_e1;
        m_e1 = e0;
        m_u  = u;
    endfunction

    function automatic void model_clear();
        m_e1 = '0;
        m_e2 = '0;
        m_u  = '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        cfg_we   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        check("rst_out", out_v, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        m_stg[addr] = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One sample: wr_at/clr_at give the edge index (0 = accept edge) at which
    // a config write / clear is driven; -1 / 0 mean none.
    task automatic run_sample(input logic [W-1:0] y, input int wr_at, input logic [1:0] wr_addr,
                              input logic [W-1:0] wr_data, input int clr_at);
        logic [W-1:0] exp_u, e0;
        bit cleared;
        int done;
        cleared = (clr_at > 0);
        done    = cleared ? clr_at : 5;
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        in_v     = y;
        in_valid = 1'b1;
        if (wr_at == 0) begin
            cfg_we   = 1'b1;
            cfg_addr = wr_addr;
            cfg_data = wr_data;
        end
        @(posedge clk);
        model_accept(y, exp_u, e0);
        exp_q.push_back(exp_u);
        if (wr_at == 0) m_stg[wr_addr] = wr_data;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            clear    = 1'b0;
            check("busy_ready", in_ready, 32'(k >= done));
            check("valid_pulse", out_valid, 32'(!cleared && k == 5));
            if (!cleared && k == 5) check("out_value", out_v, exp_q.pop_front());
            if (cleared && k == clr_at) check("out_cleared", out_v, 0);
            if (k < 6) begin
                if (k + 1 == wr_at) begin
                    cfg_we   = 1'b1;
                    cfg_addr = wr_addr;
                    cfg_data = wr_data;
                    m_stg[wr_addr] = wr_data;
                end
                if (k + 1 == clr_at) clear = 1'b1;
                @(posedge clk);
            end
        end
        if (cleared) begin
            model_clear();
            void'(exp_q.pop_front());
        end else begin
            model_commit(exp_u, e0);
        end
    endtask

    initial begin
        logic [W-1:0] exp_u, e0;
        reset    = 1'b1;
        in_v     = '0;
        in_valid = 1'b0;
        clear    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        model_reset();

        // defaults, y=100 three times: 130, 130, 195
        do_reset();
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        check("seq1", m_u, 16'd130);
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        check("seq2", m_u, 16'd130);
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        check("seq3", m_u, 16'd195);

        // y == setpoint gives zero output
        do_reset();
        run_sample(16'd165, -1, 2'd0, 16'd0, 0);

        // product wrap: K1=0x4000, e0=165
        do_reset();
        cfg_write(2'd0, 16'h4000);
        run_sample(16'd0, -1, 2'd0, 16'd0, 0);
        check("wrap_model", m_u, 16'h4000);

        // SP write during MUL0 applies to the next sample only
        do_reset();
        run_sample(16'd100, 2, 2'd3, 16'd200, 0);
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        check("sp_late", m_u, 16'd200);

        // write on the accept edge itself is deferred
        do_reset();
        run_sample(16'd100, 0, 2'd0, 16'd7, 0);
        check("same_edge", m_u, 16'd130);

        // clear during MUL1 discards the sample and the history
        do_reset();
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        run_sample(16'd100, -1, 2'd0, 16'd0, 3);
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        check("after_clear", m_u, 16'd130);

        // in_valid held high: one accept every 6 cycles
        do_reset();
        @(negedge clk);
        in_v     = 16'd100;
        in_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            if (k % 6 == 0) begin
                model_accept(16'd100, exp_u, e0);
                model_commit(exp_u, e0);
                exp_q.push_back(exp_u);
            end
            @(negedge clk);
            check("stream_valid", out_valid, 32'(k % 6 == 5));
            check("stream_ready", in_ready, 32'(k % 6 == 5));
            if (k % 6 == 5 && exp_q.size() > 0) check("stream_out", out_v, exp_q.pop_front());
        end
        in_valid = 1'b0;
        check("stream_last", m_u, 16'd260);

        // reset mid-computation restores defaults
        cfg_write(2'd0, 16'd5);
        @(negedge clk);
        in_v     = 16'd100;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        repeat (6) begin
            @(negedge clk);
            check("no_pulse", out_valid, 0);
        end
        run_sample(16'd100, -1, 2'd0, 16'd0, 0);
        check("reset_defaults", m_u, 16'd130);

        // randomized samples, writes and clears
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] y, d;
            logic [1:0]   a;
            int           wa, ca;
            y  = W'($urandom_range(0, 65535));
            a  = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 400))
                                              : W'($urandom_range(0, 65535));
            wa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            ca = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_sample(y, wa, a, d, ca);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
